reg_bank4x16: RTL and testbench

REG_BANK4X16 -- requirements
Module: reg_bank4x16

---
 rtl/reg_bank4x16.sv | 96 +++++++++
 tb/tb_reg_bank4x16.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/reg_bank4x16.sv
// Four 16-bit registers with a registered read port and a 4-cycle clear sequence.
// Define REG_BANK4X16_BYPASS_EN to forward same-cycle write data onto a matching read.
module reg_bank4x16 #(
  parameter logic [15:0] CLEAR_VALUE = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic [1:0]  address,
  input  logic        load,
  input  logic        clear,
  input  logic        rd_req,
  input  logic [1:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic [15:0] q0,
  output logic [15:0] q1,
  output logic [15:0] q2,
  output logic [15:0] q3,
  output logic        busy
);

  typedef enum logic {StIdle, StClear} state_e;

  state_e      r_state, w_state_next;
  logic [15:0] r_regs [4];
  logic [15:0] w_regs_next [4];
  logic [1:0]  r_cnt, w_cnt_next;
  logic [15:0] r_rd_data, w_rd_data_next;
  logic        r_rd_valid, w_rd_valid_next;
  logic [15:0] w_rd_src;

`ifdef REG_BANK4X16_BYPASS_EN
  // A load that is dropped by a simultaneous clear must not be forwarded.
  assign w_rd_src = (load && !clear && (rd_addr == address)) ? in : r_regs[rd_addr];
`else
  assign w_rd_src = r_regs[rd_addr];
`endif

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_rd_valid_next = 1'b0;
    w_rd_data_next  = r_rd_data;
    w_regs_next     = r_regs;
    case (r_state)
      StIdle: begin
        if (rd_req) begin
          w_rd_valid_next = 1'b1;
          w_rd_data_next  = w_rd_src;
        end
        if (clear) begin
          w_state_next = StClear;
          w_cnt_next   = 2'd0;
        end else if (load) begin
          w_regs_next[address] = in;
        end
      end
      StClear: begin
        w_regs_next[r_cnt] = CLEAR_VALUE;
        if (r_cnt == 2'd3) begin
          w_state_next = StIdle;
          w_cnt_next   = 2'd0;
        end else begin
          w_cnt_next = r_cnt + 2'd1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_cnt      <= 2'd0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= 16'h0000;
      for (int i = 0; i < 4; i++) r_regs[i] <= 16'h0000;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_rd_valid <= w_rd_valid_next;
      r_rd_data  <= w_rd_data_next;
      for (int i = 0; i < 4; i++) r_regs[i] <= w_regs_next[i];
    end
  end

  assign q0       = r_regs[0];
  assign q1       = r_regs[1];
  assign q2       = r_regs[2];
  assign q3       = r_regs[3];
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign busy     = (r_state == StClear);

endmodule

// File: tb/tb_reg_bank4x16.sv
// Directed plus randomized bench for reg_bank4x16 against a cycle-level reference model.
module tb_reg_bank4x16;

  localparam logic [15:0] CV = 16'hFFFF;

  logic        clk = 1'b0;
  logic        reset, load, clear, rd_req;
  logic [15:0] in;
  logic [1:0]  address, rd_addr;
  logic [15:0] rd_data, q0, q1, q2, q3;
  logic        rd_valid, busy;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: register array, clear progress as "cells still to clear".
  logic [15:0] m_r [4];
  int          m_clear_left;
  logic [15:0] m_rd;
  logic        m_rv;

  always #5 clk = ~clk;

  reg_bank4x16 #(.CLEAR_VALUE(CV)) dut (
    .clk(clk), .reset(reset), .in(in), .address(address), .load(load), .clear(clear),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3), .busy(busy)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mux4(input logic [1:0] sel, input logic [15:0] a,
                                       input logic [15:0] b, input logic [15:0] c,
                                       input logic [15:0] d);
    case (sel)
      2'd0:    return a;
      2'd1:    return b;
      2'd2:    return c;
      default: return d;
    endcase
  endfunction

  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < 4; i++) m_r[i] = 16'h0000;
      m_clear_left = 0;
      m_rd = 16'h0000;
      m_rv = 1'b0;
    end else if (m_clear_left > 0) begin
      m_r[4 - m_clear_left] = CV;
      m_clear_left--;
      m_rv = 1'b0;
    end else begin
      m_rv = rd_req;
      if (rd_req) begin
        m_rd = m_r[rd_addr];
`ifdef REG_BANK4X16_BYPASS_EN
        if (load && !clear && rd_addr == address) m_rd = in;
`endif
      end
      if (clear) m_clear_left = 4;
      else if (load) m_r[address] = in;
    end
  endtask

  task automatic check_all();
    check("q0", q0, m_r[0]);
    check("q1", q1, m_r[1]);
    check("q2", q2, m_r[2]);
    check("q3", q3, m_r[3]);
    check("busy", {15'd0, busy}, {15'd0, m_clear_left > 0});
    check("rd_valid", {15'd0, rd_valid}, {15'd0, m_rv});
    check("rd_data", rd_data, m_rd);
  endtask

  task automatic step(input logic rst, input logic ld, input logic [1:0] addr,
                      input logic [15:0] din, input logic clr, input logic rq,
                      input logic [1:0] raddr);
    reset = rst; load = ld; address = addr; in = din; clear = clr;
    rd_req = rq; rd_addr = raddr;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; clear = 1'b0; rd_req = 1'b0;
    in = '0; address = '0; rd_addr = '0;
    // Reset state
    step(1, 0, 0, 16'h0, 0, 0, 0);
    check("rst_q0", q0, 16'h0000);
    check("rst_q3", q3, 16'h0000);
    check("rst_busy", {15'd0, busy}, 16'h0);
    check("rst_rd_valid", {15'd0, rd_valid}, 16'h0);

    // Load one-hot patterns and look through a downstream mux
    for (int i = 0; i < 4; i++) step(0, 1, 2'(i), 16'h1 << i, 0, 0, 0);
    check("load_q0", q0, 16'h0001);
    check("load_q1", q1, 16'h0002);
    check("load_q2", q2, 16'h0004);
    check("load_q3", q3, 16'h0008);
    for (int s = 0; s < 4; s++) check("mux_sel", mux4(2'(s), q0, q1, q2, q3), 16'h1 << s);

    // Single read, then pulse drops
    step(0, 0, 0, 16'h0, 0, 1, 2);
    check("rd2_valid", {15'd0, rd_valid}, 16'h1);
    check("rd2_data", rd_data, 16'h0004);
    step(0, 0, 0, 16'h0, 0, 0, 0);
    check("rd2_after", {15'd0, rd_valid}, 16'h0);

    // Clear sequence with loads and reads attempted while busy
    step(0, 0, 0, 16'h0, 1, 0, 0);
    check("clr_busy_e0", {15'd0, busy}, 16'h1);
    check("clr_q0_e0", q0, 16'h0001);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 16'h1111, 1, 1, 0);
      check("clr_rdv_busy", {15'd0, rd_valid}, 16'h0);
    end
    check("clr_busy_done", {15'd0, busy}, 16'h0);
    check("clr_q0", q0, CV);
    check("clr_q3", q3, CV);

    // Read-during-write on the same register
    for (int i = 0; i < 4; i++) step(0, 1, 2'(i), 16'h1 << i, 0, 0, 0);
    step(0, 1, 1, 16'hABCD, 0, 1, 1);
`ifdef REG_BANK4X16_BYPASS_EN
    check("rdw_data", rd_data, 16'hABCD);
`else
    check("rdw_data", rd_data, 16'h0002);
`endif
    check("rdw_q1", q1, 16'hABCD);

    // Reset two cycles into a clear aborts it
    step(0, 0, 0, 16'h0, 1, 0, 0);
    step(0, 0, 0, 16'h0, 0, 0, 0);
    step(0, 0, 0, 16'h0, 0, 0, 0);
    step(1, 0, 0, 16'h0, 0, 0, 0);
    check("abort_busy", {15'd0, busy}, 16'h0);
    step(0, 0, 0, 16'h0, 0, 0, 0);
    step(0, 0, 0, 16'h0, 0, 1, 3);
    check("abort_q2", q2, 16'h0000);
    check("abort_rd", rd_data, 16'h0000);
    check("abort_rdv", {15'd0, rd_valid}, 16'h1);

    // Clear with simultaneous load (dropped) and read (pre-clear value)
    step(0, 1, 3, 16'h5555, 0, 0, 0);
    step(0, 1, 3, 16'h1234, 1, 1, 3);
    check("clrld_rd", rd_data, 16'h5555);
    check("clrld_q3", q3, 16'h5555);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 16'h0, 0, 0, 0);
    check("clrld_q3_end", q3, CV);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) == 0), 1'($urandom), 2'($urandom), 16'($urandom),
           ($urandom_range(0, 9) == 0), 1'($urandom), 2'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
